// File: rtl/div_req_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_req_sequencer: request FIFO + start/done sequencer for a seq. divider  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module div_req_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_divzero,
  output logic             rsp_timeout,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   C_FULL   = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] C_WD_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;

  logic [WIDTH-1:0] r_mem_dividend [DEPTH];
  logic [WIDTH-1:0] r_mem_divisor  [DEPTH];
  logic [TAG_W-1:0] r_mem_tag      [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic [WIDTH-1:0] r_op_dividend;
  logic [WIDTH-1:0] r_op_divisor;
  logic [CNT_W-1:0] r_wdog;

  logic w_push;
  logic w_pop;
  logic w_not_empty;

  assign w_not_empty = (r_count != '0);
  assign req_ready   = (r_count != C_FULL);
  assign w_push      = req_valid && req_ready;
  assign w_pop       = (r_state == S_IDLE) && w_not_empty;

  assign div_dividend = r_op_dividend;
  assign div_divisor  = r_op_divisor;
  assign busy         = (r_state != S_IDLE) || w_not_empty;

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_dividend[r_wr_ptr] <= req_dividend;
      r_mem_divisor[r_wr_ptr]  <= req_divisor;
      r_mem_tag[r_wr_ptr]      <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op_dividend <= '0;
      r_op_divisor  <= '0;
      r_wdog        <= '0;
      div_start     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_tag       <= '0;
      rsp_divzero   <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_not_empty) begin
            r_op_dividend <= r_mem_dividend[r_rd_ptr];
            r_op_divisor  <= r_mem_divisor[r_rd_ptr];
            rsp_tag       <= r_mem_tag[r_rd_ptr];
            rsp_divzero   <= 1'b0;
            rsp_timeout   <= 1'b0;
            if (r_mem_divisor[r_rd_ptr] != '0) begin
              div_start <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              // Divide-by-zero is answered locally; the divider is never started.
              rsp_quotient  <= '1;
              rsp_remainder <= r_mem_dividend[r_rd_ptr];
              rsp_divzero   <= 1'b1;
              rsp_valid     <= 1'b1;
              r_state       <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wdog <= r_wdog + CNT_W'(1);
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_valid     <= 1'b1;
            r_state       <= S_RESP;
          end else if (r_wdog == C_WD_MAX) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/div_req_sequencer.md
Name: div_req_sequencer

Overview:
- Front-end stage that sits directly upstream of the team's multi-cycle sequential divider.
- Accepts divide requests on a valid/ready interface and buffers them in a small FIFO.
- Issues one start pulse per request to the divider, waits for its done, and returns tagged quotient/remainder on a valid/ready response interface.
- Handles divide-by-zero locally without starting the divider, and bounds each divide with a watchdog timeout.

Parameters:
- WIDTH, 32: operand and result width.
- TAG_W, 4: request tag width.
- DEPTH, 4: request FIFO depth; must be a power of 2 and at least 2.
- TIMEOUT, 64: maximum WAIT cycles before the divide is abandoned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request FIFO not full
- req_dividend  in  WIDTH  dividend
- req_divisor  in  WIDTH  divisor
- req_tag  in  TAG_W  request tag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_quotient  out  WIDTH  quotient
- rsp_remainder  out  WIDTH  remainder
- rsp_tag  out  TAG_W  tag of the answered request
- rsp_divzero  out  1  divisor was 0
- rsp_timeout  out  1  divider did not finish within TIMEOUT cycles
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  WIDTH  operand to the divider
- div_divisor  out  WIDTH  operand to the divider
- div_done  in  1  divider done (level)
- div_quotient  in  WIDTH  divider quotient
- div_remainder  in  WIDTH  divider remainder
- busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: FIFO empty, FSM IDLE, and every registered output is 0. req_ready is 1 after reset because the FIFO is empty.
- FIFO:
  - Write on req_valid && req_ready.
  - req_ready = !full, a function of occupancy only. It stays low when full even if a pop happens in the same cycle.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is not empty: pop and latch dividend, divisor and tag into operand registers.
  - If divisor != 0, go to ISSUE.
  - If divisor == 0, go to RESP with quotient = all ones, remainder = dividend, rsp_divzero = 1.
- ISSUE:
  - div_start = 1 for exactly this cycle.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - div_dividend and div_divisor are held stable from the operand registers; they are driven from these registers in all states.
  - The watchdog counter increments every cycle.
  - If div_done == 1, capture div_quotient and div_remainder and go to RESP.
  - Else, when the counter reaches TIMEOUT-1, go to RESP with quotient = 0, remainder = 0, rsp_timeout = 1.
  - div_done takes priority over timeout in the same cycle.
- RESP:
  - rsp_valid = 1 and all rsp_* fields are held stable until rsp_ready; on that handshake go to IDLE.
  - rsp_divzero and rsp_timeout are cleared when the next request is latched.
- div_done is sampled only in WAIT. Any level in IDLE, ISSUE or RESP, including the post-reset done from the divider, is ignored.
- Latency (request accepted at edge k, FIFO empty, FSM IDLE):
  - Pop at edge k+1.
  - Divide-by-zero: rsp_valid is high from edge k+1.
  - Normal divide: start is seen by the divider at edge k+2. If the divider raises done at edge k+2+D, rsp_valid is high from edge k+3+D.
- Throughput: one request in flight; the next pop occurs in the IDLE cycle after the response handshake.
- Reset mid-operation: FIFO contents are discarded and div_start drops immediately. Any result still in flight from the divider is ignored.

Test Plan:
- Bench uses WIDTH=8 and a divider model with D=10. Send 100/7, tag 3, rsp_ready=1 -> div_start pulses once; rsp_valid at edge k+13 with quotient 14, remainder 2, tag 3, both flags 0.
- Send 55/0, tag 9 -> div_start never asserts; rsp_valid at edge k+1 with quotient 0xFF, remainder 55, rsp_divzero=1.
- Send DEPTH+2 back-to-back requests with rsp_ready=0 -> req_ready drops once DEPTH are queued (one popped into the FSM). Release rsp_ready -> all responses return in order with correct tags and no loss or duplication.
- Divider model never raises done, TIMEOUT=64 -> rsp_valid after 64 WAIT cycles with rsp_timeout=1 and zero results. The next request then completes normally.
- Divider model holds done=1 from reset, then send 9/3 -> stale done is ignored and the response is quotient 3, remainder 0 at the correct latency.
- Assert rst_n low in mid-WAIT with 2 requests queued -> all outputs reset and busy=0. Post-reset traffic completes correctly.
